// File: rtl/dm_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_bus_pkg : width codes and FSM encoding for dm_bus_bridge        |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package dm_bus_pkg;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_WAIT = 2'd1,
        IO_DONE = 2'd2
    } bridge_state_t;

endpackage : dm_bus_pkg
`default_nettype wire

// File: rtl/dm_bus_bridge_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_lane_unit : store lane/byte-enable generation, load extract and |
// |                extend, misalignment detection (combinational)      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module dm_lane_unit
    import dm_bus_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_ctrl,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] lane_wdata,
    output logic [3:0]  be,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [31:0] w_shifted;
    logic [15:0] w_half;

    always_comb begin
        lane_wdata = wdata;
        be         = 4'b1111;
        rdata_ext  = rword;
        misalign   = 1'b0;
        w_shifted  = rword >> {addr_lo, 3'b000};
        w_half     = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (dm_ctrl)
            DM_BYTE, DM_BYTE_U: begin
                lane_wdata = {4{wdata[7:0]}};
                be         = 4'b0001 << addr_lo;
                if (dm_ctrl == DM_BYTE)
                    rdata_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
                else
                    rdata_ext = {24'h000000, w_shifted[7:0]};
            end
            DM_HALF, DM_HALF_U: begin
                lane_wdata = {2{wdata[15:0]}};
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign   = addr_lo[0];
                if (dm_ctrl == DM_HALF)
                    rdata_ext = {{16{w_half[15]}}, w_half};
                else
                    rdata_ext = {16'h0000, w_half};
            end
            // Word, plus the undefined codes which behave as word.
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule : dm_lane_unit
`default_nettype wire

// File: rtl/dm_bus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dm_bus_bridge : CPU memory-stage bridge to data RAM and req/ack    |
// |                 peripheral bus with stall and timeout handling     |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module dm_bus_bridge
    import dm_bus_pkg::*;
#(
    parameter int          RAM_AW     = 10,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_mem_w,
    input  logic              cpu_mem_r,
    input  logic [2:0]        cpu_dm_ctrl,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              misalign,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic              io_req,
    output logic              io_we,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_be,
    input  logic              io_ack,
    input  logic [31:0]       io_rdata
);

    localparam logic [7:0] c_timeout_last = 8'(IO_TIMEOUT - 1);

    bridge_state_t r_state;
    bridge_state_t w_next_state;
    logic [7:0]    r_cnt;
    logic [31:0]   r_rdata_cap;
    logic          r_bus_err;
    logic          r_io_req;
    logic          r_io_we;
    logic [31:0]   r_io_addr;
    logic [31:0]   r_io_wdata;
    logic [3:0]    r_io_be;

    logic [31:0]   w_lane_wdata;
    logic [3:0]    w_be;
    logic [31:0]   w_ram_rdata_ext;
    logic          w_misalign;
    logic [31:0]   w_io_rdata_ext;
    logic [31:0]   w_unused_io_wdata;
    logic [3:0]    w_unused_io_be;
    logic          w_unused_io_misalign;

    logic          w_req;
    logic          w_is_io;
    logic          w_start_io;

    dm_lane_unit u_cpu_lane (
        .addr_lo    (cpu_addr[1:0]),
        .dm_ctrl    (cpu_dm_ctrl),
        .wdata      (cpu_wdata),
        .rword      (ram_rdata),
        .lane_wdata (w_lane_wdata),
        .be         (w_be),
        .rdata_ext  (w_ram_rdata_ext),
        .misalign   (w_misalign)
    );

    // Extracts the captured peripheral word; dm_ctrl is stable across the stall.
    dm_lane_unit u_io_lane (
        .addr_lo    (r_io_addr[1:0]),
        .dm_ctrl    (cpu_dm_ctrl),
        .wdata      (r_io_wdata),
        .rword      (r_rdata_cap),
        .lane_wdata (w_unused_io_wdata),
        .be         (w_unused_io_be),
        .rdata_ext  (w_io_rdata_ext),
        .misalign   (w_unused_io_misalign)
    );

    assign w_req      = cpu_mem_w | cpu_mem_r;
    assign w_is_io    = (cpu_addr >= IO_BASE);
    assign w_start_io = w_req & w_is_io & ~w_misalign & (r_state == IDLE);

    assign ram_addr  = cpu_addr[RAM_AW+1:2];
    assign ram_wdata = w_lane_wdata;
    assign bus_err   = r_bus_err;
    assign io_req    = r_io_req;
    assign io_we     = r_io_we;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;
    assign io_be     = r_io_be;

    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b1;
        cpu_rdata    = 32'h0000_0000;
        ram_we       = 1'b0;
        ram_be       = 4'b0000;
        misalign     = 1'b0;

        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_misalign) begin
                            misalign = 1'b1;
                        end else if (!w_is_io) begin
                            ram_we    = cpu_mem_w;
                            ram_be    = w_be;
                            cpu_rdata = w_ram_rdata_ext;
                        end else begin
                            cpu_ready    = 1'b0;
                            w_next_state = IO_WAIT;
                        end
                    end
                end
                IO_WAIT: begin
                    cpu_ready = 1'b0;
                    if (io_ack || (r_cnt == c_timeout_last))
                        w_next_state = IO_DONE;
                end
                IO_DONE: begin
                    cpu_rdata    = w_io_rdata_ext;
                    w_next_state = IDLE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_rdata_cap <= 32'h0000_0000;
            r_bus_err   <= 1'b0;
            r_io_req    <= 1'b0;
            r_io_we     <= 1'b0;
            r_io_addr   <= 32'h0000_0000;
            r_io_wdata  <= 32'h0000_0000;
            r_io_be     <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_start_io) begin
                        r_io_req   <= 1'b1;
                        r_io_we    <= cpu_mem_w;
                        r_io_addr  <= cpu_addr;
                        r_io_wdata <= w_lane_wdata;
                        r_io_be    <= w_be;
                        r_cnt      <= 8'd0;
                    end
                end
                IO_WAIT: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (io_ack) begin
                        r_rdata_cap <= io_rdata;
                        r_io_req    <= 1'b0;
                    end else if (r_cnt == c_timeout_last) begin
                        r_rdata_cap <= 32'h0000_0000;
                        r_bus_err   <= 1'b1;
                        r_io_req    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : dm_bus_bridge
`default_nettype wire
